// File: rtl/loader_pkg.sv
// Shared types and helpers for the ROM region loader.
package loader_pkg;

  localparam int unsigned MaxReg = 8;
  localparam int unsigned AddrW  = 25;

  // Default ioctl_index values used by hps_io.
  localparam logic [7:0] IdxRom = 8'd0;
  localparam logic [7:0] IdxMod = 8'd1;
  localparam logic [7:0] IdxDip = 8'd254;

  // Per-region byte counter; also used for byte addresses and offsets.
  typedef logic [AddrW-1:0] cnt_t;

  // Packed base/size vector sized for the largest region count.
  typedef logic [AddrW*MaxReg-1:0] reg_vec_t;

  function automatic cnt_t region_base(input reg_vec_t bases, input int unsigned i);
    return bases[AddrW*i +: AddrW];
  endfunction

  function automatic cnt_t region_size(input reg_vec_t sizes, input int unsigned i);
    return sizes[AddrW*i +: AddrW];
  endfunction

endpackage

// File: rtl/loader_pack.sv
// Byte-to-word packer. With one byte per word it is a plain output register;
// with two it pairs even/odd bytes and flushes a dangling even byte on request.
module loader_pack
  import loader_pkg::*;
#(
  parameter int unsigned NREG = 4,
  parameter int unsigned RAW  = 16,
  parameter int unsigned DWB  = 1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [NREG-1:0]  in_sel,
  input  cnt_t             in_off,
  input  logic [7:0]       in_byte,
  input  logic             flush,
  output logic [NREG-1:0]  rom_we,
  output logic [RAW-1:0]   rom_addr,
  output logic [8*DWB-1:0] rom_data
);

  logic [NREG-1:0]  we_d, we_q;
  logic [RAW-1:0]   addr_d, addr_q;
  logic [8*DWB-1:0] data_d, data_q;

  // Output registers; address and data hold their last value between strobes.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      we_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign rom_we   = we_q;
  assign rom_addr = addr_q;
  assign rom_data = data_q;

  if (DWB == 1) begin : g_pass
    logic unused_pass;
    assign unused_pass = ^{clear, flush, in_off};

    // Every accepted byte is a complete word.
    always_comb begin
      we_d   = '0;
      addr_d = addr_q;
      data_d = data_q;
      if (in_valid) begin
        we_d   = in_sel;
        addr_d = in_off[RAW-1:0];
        data_d = in_byte;
      end
    end
  end else begin : g_pack
    logic            lat_vld_d, lat_vld_q;
    logic [NREG-1:0] lat_sel_d, lat_sel_q;
    logic [RAW-1:0]  lat_addr_d, lat_addr_q;
    logic [7:0]      lat_byte_d, lat_byte_q;
    logic            lat_pair;
    cnt_t            in_woff;
    logic            unused_pack;

    assign in_woff     = in_off >> 1;
    assign unused_pack = ^in_woff;
    // An odd byte only pairs with an even byte latched for the same region.
    assign lat_pair    = lat_vld_q && !clear && (lat_sel_q == in_sel);

    // Low-byte latch state.
    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        lat_vld_q  <= 1'b0;
        lat_sel_q  <= '0;
        lat_addr_q <= '0;
        lat_byte_q <= '0;
      end else begin
        lat_vld_q  <= lat_vld_d;
        lat_sel_q  <= lat_sel_d;
        lat_addr_q <= lat_addr_d;
        lat_byte_q <= lat_byte_d;
      end
    end

    // Even bytes wait in the latch, odd bytes complete a word, flush drains a leftover.
    always_comb begin
      we_d       = '0;
      addr_d     = addr_q;
      data_d     = data_q;
      lat_vld_d  = lat_vld_q && !clear;
      lat_sel_d  = lat_sel_q;
      lat_addr_d = lat_addr_q;
      lat_byte_d = lat_byte_q;
      if (in_valid) begin
        if (!in_off[0]) begin
          lat_vld_d  = 1'b1;
          lat_sel_d  = in_sel;
          lat_addr_d = in_woff[RAW-1:0];
          lat_byte_d = in_byte;
        end else begin
          we_d      = in_sel;
          addr_d    = in_woff[RAW-1:0];
          data_d    = {in_byte, lat_pair ? lat_byte_q : 8'h00};
          lat_vld_d = 1'b0;
        end
      end else if (flush && lat_vld_q) begin
        we_d      = lat_sel_q;
        addr_d    = lat_addr_q;
        data_d    = {8'h00, lat_byte_q};
        lat_vld_d = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rom_region_loader.sv
// Routes hps_io download bytes into ROM regions, captures the core-mod and
// DIP bytes, and reports per-region completion and out-of-map errors.
module rom_region_loader
  import loader_pkg::*;
#(
  parameter int unsigned        NREG     = 4,
  parameter int unsigned        RAW      = 16,
  parameter int unsigned        DWB      = 1,
  parameter logic [25*NREG-1:0] REG_BASE = '0,
  parameter logic [25*NREG-1:0] REG_SIZE = '0,
  parameter logic [7:0]         ROM_IDX  = IdxRom,
  parameter logic [7:0]         MOD_IDX  = IdxMod,
  parameter logic [7:0]         DIP_IDX  = IdxDip,
  parameter int unsigned        NDIP     = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  output logic [NREG-1:0]   rom_we,
  output logic [RAW-1:0]    rom_addr,
  output logic [8*DWB-1:0]  rom_data,
  output logic [NREG-1:0]   region_done,
  output logic              dl_busy,
  output logic              dl_done,
  output logic              map_err,
  output logic [7:0]        core_mod,
  output logic [8*NDIP-1:0] dip_sw
);

  localparam reg_vec_t BaseVec = reg_vec_t'(REG_BASE);
  localparam reg_vec_t SizeVec = reg_vec_t'(REG_SIZE);

  cnt_t base_a [NREG];
  cnt_t size_a [NREG];

  for (genvar g = 0; g < NREG; g++) begin : g_region
    assign base_a[g] = region_base(BaseVec, g);
    assign size_a[g] = region_size(SizeVec, g);
  end

  // Download edge detection on the registered copy of ioctl_download.
  logic dl_q, dl_qq;
  logic dl_rise, dl_fall, rom_rise, rom_fall;
  logic dl_busy_q, dl_done_q, map_err_q;
  logic [NREG-1:0] region_done_q, done_now;

  assign dl_rise  = dl_q & ~dl_qq;
  assign dl_fall  = ~dl_q & dl_qq;
  assign rom_rise = dl_rise & (ioctl_index == ROM_IDX);
  // Only the end of a ROM download updates ROM status and flushes the packer.
  assign rom_fall = dl_fall & dl_busy_q;

  // Download level history.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_q  <= 1'b0;
      dl_qq <= 1'b0;
    end else begin
      dl_q  <= ioctl_download;
      dl_qq <= dl_q;
    end
  end

  // Region decode: lowest-indexed window containing the byte address wins.
  logic            rom_wr;
  logic [NREG-1:0] hit_sel;
  cnt_t            hit_off;
  logic            hit_any;

  assign rom_wr  = ioctl_wr & ioctl_download & (ioctl_index == ROM_IDX);
  assign hit_any = |hit_sel;

  // Window compare done in 26 bits so base + size cannot wrap.
  always_comb begin
    hit_sel = '0;
    hit_off = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (hit_sel == '0 &&
          {1'b0, ioctl_addr} >= {1'b0, base_a[i]} &&
          {1'b0, ioctl_addr} < ({1'b0, base_a[i]} + {1'b0, size_a[i]})) begin
        hit_sel[i] = 1'b1;
        hit_off    = ioctl_addr - base_a[i];
      end
    end
  end

  logic            s1_valid_q;
  logic [NREG-1:0] s1_sel_q;
  cnt_t            s1_off_q;
  logic [7:0]      s1_byte_q;

  // Decode stage register; out-of-map bytes never reach the packer.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_sel_q   <= '0;
      s1_off_q   <= '0;
      s1_byte_q  <= '0;
    end else begin
      s1_valid_q <= rom_wr & hit_any;
      if (rom_wr) begin
        s1_sel_q  <= hit_sel;
        s1_off_q  <= hit_off;
        s1_byte_q <= ioctl_dout;
      end
    end
  end

  cnt_t cnt_q [NREG];

  // Per-region byte counters; a byte landing on the rise cycle still counts.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt_q[i] <= (rom_rise ? '0 : cnt_q[i]) + cnt_t'(s1_valid_q & s1_sel_q[i]);
      end
    end
  end

  // A region is complete when exactly its size in bytes has arrived.
  always_comb begin
    done_now = '0;
    for (int unsigned i = 0; i < NREG; i++) done_now[i] = (cnt_q[i] == size_a[i]);
  end

  // ROM download status; a map error raised on the rise cycle is kept.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_busy_q     <= 1'b0;
      dl_done_q     <= 1'b0;
      map_err_q     <= 1'b0;
      region_done_q <= '0;
    end else begin
      if (rom_rise) begin
        dl_busy_q     <= 1'b1;
        dl_done_q     <= 1'b0;
        region_done_q <= '0;
      end else if (dl_fall) begin
        dl_busy_q <= 1'b0;
        if (dl_busy_q) begin
          dl_done_q     <= ~map_err_q;
          region_done_q <= done_now;
        end
      end
      if (rom_rise) map_err_q <= 1'b0;
      if (rom_wr && !hit_any) map_err_q <= 1'b1;
    end
  end

  loader_pack #(
    .NREG (NREG),
    .RAW  (RAW),
    .DWB  (DWB)
  ) u_pack (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .clear    (rom_rise),
    .in_valid (s1_valid_q),
    .in_sel   (s1_sel_q),
    .in_off   (s1_off_q),
    .in_byte  (s1_byte_q),
    .flush    (rom_fall),
    .rom_we   (rom_we),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  logic [7:0] mod_shadow_q, core_mod_q;

  // Mod byte is shadowed and only applied at download end so core select never glitches.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mod_shadow_q <= '0;
      core_mod_q   <= '0;
    end else begin
      if (ioctl_wr && ioctl_index == MOD_IDX) mod_shadow_q <= ioctl_dout;
      if (dl_fall) core_mod_q <= mod_shadow_q;
    end
  end

  logic [8*NDIP-1:0] dip_q;

  // DIP bytes land immediately; addresses beyond NDIP are dropped.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dip_q <= '0;
    end else if (ioctl_wr && ioctl_index == DIP_IDX) begin
      for (int unsigned k = 0; k < NDIP; k++) begin
        if (ioctl_addr == cnt_t'(k)) dip_q[8*k +: 8] <= ioctl_dout;
      end
    end
  end

  assign region_done = region_done_q;
  assign dl_busy     = dl_busy_q;
  assign dl_done     = dl_done_q;
  assign map_err     = map_err_q;
  assign core_mod    = core_mod_q;
  assign dip_sw      = dip_q;

endmodule

// File: tb/tb_rom_region_loader.sv
// Directed and randomized bench for rom_region_loader: one byte-wide instance
// with three regions and one word-wide instance with two small regions.
module tb_rom_region_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        dl   [2];
  logic        wr   [2];
  logic [24:0] addr [2];
  logic [7:0]  dout [2];
  logic [7:0]  idx  [2];

  logic [2:0]  we_a, done_a;
  logic [15:0] addr_a;
  logic [7:0]  data_a, mod_a;
  logic        busy_a, ddone_a, err_a;
  logic [63:0] dip_a;

  logic [1:0]  we_b, done_b;
  logic [7:0]  addr_b, mod_b;
  logic [15:0] data_b;
  logic        busy_b, ddone_b, err_b;
  logic [63:0] dip_b;

  rom_region_loader #(
    .NREG (3), .RAW (16), .DWB (1),
    .REG_BASE ({25'hFF0, 25'hE00, 25'h000}),
    .REG_SIZE ({25'h1000, 25'h100, 25'h800})
  ) u_dut_a (
    .clk_sys (clk), .reset (rst), .ioctl_download (dl[0]), .ioctl_wr (wr[0]),
    .ioctl_addr (addr[0]), .ioctl_dout (dout[0]), .ioctl_index (idx[0]),
    .rom_we (we_a), .rom_addr (addr_a), .rom_data (data_a), .region_done (done_a),
    .dl_busy (busy_a), .dl_done (ddone_a), .map_err (err_a), .core_mod (mod_a),
    .dip_sw (dip_a)
  );

  rom_region_loader #(
    .NREG (2), .RAW (8), .DWB (2),
    .REG_BASE ({25'h10, 25'h0}),
    .REG_SIZE ({25'h6, 25'h4})
  ) u_dut_b (
    .clk_sys (clk), .reset (rst), .ioctl_download (dl[1]), .ioctl_wr (wr[1]),
    .ioctl_addr (addr[1]), .ioctl_dout (dout[1]), .ioctl_index (idx[1]),
    .rom_we (we_b), .rom_addr (addr_b), .rom_data (data_b), .region_done (done_b),
    .dl_busy (busy_b), .dl_done (ddone_b), .map_err (err_b), .core_mod (mod_b),
    .dip_sw (dip_b)
  );

  // Reference model: region maps, byte counts, error flag, expected word writes.
  typedef struct { int r; int a; int v; } exp_t;
  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int mbase [2][3] = '{'{0, 'hE00, 'hFF0}, '{0, 'h10, 0}};
  int msize [2][3] = '{'{'h800, 'h100, 'h1000}, '{4, 6, 0}};
  int nregm [2]    = '{3, 2};
  int cnt_m [2][3];
  bit err_m [2];
  bit lat_v;
  int lat_r, lat_off, lat_b;

  int strobe_cnt [2][3];
  int first_cyc [2] = '{-1, -1};
  int last_cyc  [2] = '{-1, -1};
  int first_wr = -1;
  int checks = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int region_of(input int d, input int a);
    for (int r = 0; r < nregm[d]; r++) begin
      if (a >= mbase[d][r] && a < mbase[d][r] + msize[d][r]) return r;
    end
    return -1;
  endfunction

  task automatic model_start(input int d);
    for (int r = 0; r < 3; r++) cnt_m[d][r] = 0;
    err_m[d] = 1'b0;
    if (d == 1) lat_v = 1'b0;
  endtask

  task automatic model_byte(input int d, input int a, input int v);
    int r;
    int off;
    r = region_of(d, a);
    if (r < 0) begin
      err_m[d] = 1'b1;
      return;
    end
    cnt_m[d][r]++;
    off = a - mbase[d][r];
    if (d == 0) begin
      exp_q0.push_back('{r, off, v});
    end else if (off % 2 == 0) begin
      lat_v = 1'b1; lat_r = r; lat_off = off; lat_b = v;
    end else begin
      exp_q1.push_back('{r, off / 2, (v << 8) | ((lat_v && lat_r == r) ? lat_b : 0)});
      lat_v = 1'b0;
    end
  endtask

  task automatic chk_strobe(input int d, input logic [7:0] we, input int a, input int v);
    exp_t e;
    logic have;
    have = 1'b0;
    if (d == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
    if (d == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
    checks++;
    assert (have === 1'b1) else begin
      fails++;
      $error("FAIL strobe_unexpected dut=%0d observed_we=%0h expected=none", d, we);
    end
    if (have) begin
      check($sformatf("strobe_we_%0d", d), 64'(we), 64'(1) << e.r);
      check($sformatf("strobe_addr_%0d", d), 64'(a), 64'(e.a));
      check($sformatf("strobe_data_%0d", d), 64'(v), 64'(e.v));
      strobe_cnt[d][e.r]++;
    end
    if (first_cyc[d] < 0) first_cyc[d] = cyc;
    last_cyc[d] = cyc;
  endtask

  always @(negedge clk) if (!rst && we_a !== 3'b0) chk_strobe(0, 8'(we_a), int'(addr_a), int'(data_a));
  always @(negedge clk) if (!rst && we_b !== 2'b0) chk_strobe(1, 8'(we_b), int'(addr_b), int'(data_b));

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_dl(input int d, input logic [7:0] index);
    idx[d] = index;
    dl[d]  = 1'b1;
    if (index == 8'd0) model_start(d);
    idle(3);
  endtask

  task automatic wr_byte(input int d, input int a, input logic [7:0] v);
    if (d == 0 && idx[d] == 8'd0 && first_wr < 0) first_wr = cyc;
    addr[d] = 25'(a);
    dout[d] = v;
    wr[d]   = 1'b1;
    if (idx[d] == 8'd0) model_byte(d, a, int'(v));
    @(posedge clk);
    #1;
    wr[d] = 1'b0;
  endtask

  task automatic end_dl(input int d, output int c0);
    idle(4);
    dl[d] = 1'b0;
    c0 = cyc;
    if (d == 1 && idx[d] == 8'd0 && lat_v) begin
      exp_q1.push_back('{lat_r, lat_off / 2, lat_b});
      lat_v = 1'b0;
    end
    idle(6);
  endtask

  task automatic rom_end_checks(input int d, input string tag);
    logic [2:0] rd;
    rd = '0;
    for (int r = 0; r < nregm[d]; r++) rd[r] = (cnt_m[d][r] == msize[d][r]);
    if (d == 0) begin
      check({tag, "_pending"}, 64'(exp_q0.size()), 64'(0));
      check({tag, "_region_done"}, 64'(done_a), 64'(rd));
      check({tag, "_dl_done"}, 64'(ddone_a), 64'(!err_m[0]));
      check({tag, "_map_err"}, 64'(err_a), 64'(err_m[0]));
      check({tag, "_dl_busy"}, 64'(busy_a), 64'(0));
    end else begin
      check({tag, "_pending"}, 64'(exp_q1.size()), 64'(0));
      check({tag, "_region_done"}, 64'(done_b), 64'(rd[1:0]));
      check({tag, "_dl_done"}, 64'(ddone_b), 64'(!err_m[1]));
      check({tag, "_map_err"}, 64'(err_b), 64'(err_m[1]));
      check({tag, "_dl_busy"}, 64'(busy_b), 64'(0));
    end
  endtask

  task automatic zero_checks(input string tag);
    check({tag, "_we_a"}, 64'(we_a), 64'(0));
    check({tag, "_addr_a"}, 64'(addr_a), 64'(0));
    check({tag, "_data_a"}, 64'(data_a), 64'(0));
    check({tag, "_done_a"}, 64'(done_a), 64'(0));
    check({tag, "_flags_a"}, 64'({busy_a, ddone_a, err_a}), 64'(0));
    check({tag, "_mod_a"}, 64'(mod_a), 64'(0));
    check({tag, "_dip_a"}, dip_a, 64'(0));
    check({tag, "_we_b"}, 64'(we_b), 64'(0));
    check({tag, "_data_b"}, 64'(data_b), 64'(0));
    check({tag, "_flags_b"}, 64'({busy_b, ddone_b, err_b, done_b}), 64'(0));
  endtask

  initial begin
    int c0;
    logic [7:0] rv;
    for (int d = 0; d < 2; d++) begin
      dl[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; dout[d] = '0; idx[d] = '0;
      for (int r = 0; r < 3; r++) begin cnt_m[d][r] = 0; strobe_cnt[d][r] = 0; end
      err_m[d] = 1'b0;
    end
    lat_v = 1'b0;

    // Reset state
    idle(3);
    zero_checks("in_reset");
    rst = 1'b0;
    idle(2);
    zero_checks("after_reset");

    // Mod byte is held back until the download ends
    start_dl(0, 8'd1);
    check("mod_busy", 64'(busy_a), 64'(0));
    wr_byte(0, 0, 8'h03);
    idle(4);
    check("mod_mid", 64'(mod_a), 64'(0));
    end_dl(0, c0);
    check("mod_end", 64'(mod_a), 64'h03);
    check("mod_no_dl_done", 64'(ddone_a), 64'(0));
    check("mod_no_region_done", 64'(done_a), 64'(0));

    // DIP capture
    start_dl(0, 8'd254);
    wr_byte(0, 0, 8'h5A);
    wr_byte(0, 9, 8'hFF);
    idle(2);
    check("dip_first", dip_a, 64'h5A);
    rv = 8'($urandom);
    wr_byte(0, 7, rv);
    idle(2);
    check("dip_byte7", dip_a, {rv, 48'h0, 8'h5A});
    end_dl(0, c0);

    // Full stream through three regions with two holes
    start_dl(0, 8'd0);
    check("stream_busy", 64'(busy_a), 64'(1));
    for (int a = 0; a < 'h1FF0; a++) begin
      wr_byte(0, a, 8'($urandom));
      if ($urandom_range(0, 15) == 0) idle($urandom_range(1, 3));
    end
    check("stream_err_mid", 64'(err_a), 64'(1));
    end_dl(0, c0);
    rom_end_checks(0, "stream");
    check("stream_region_done", 64'(done_a), 64'b111);
    check("stream_cnt0", 64'(strobe_cnt[0][0]), 64'h800);
    check("stream_cnt1", 64'(strobe_cnt[0][1]), 64'h100);
    check("stream_cnt2", 64'(strobe_cnt[0][2]), 64'h1000);
    check("stream_latency", 64'(first_cyc[0]), 64'(first_wr + 2));

    // Word packing: a full region
    start_dl(1, 8'd0);
    wr_byte(1, 0, 8'hAA);
    wr_byte(1, 1, 8'hBB);
    wr_byte(1, 2, 8'hCC);
    wr_byte(1, 3, 8'hDD);
    end_dl(1, c0);
    rom_end_checks(1, "pack_full");
    check("pack_full_done", 64'(done_b), 64'b01);
    check("pack_full_data", 64'(data_b), 64'hDDCC);

    // Word packing: dangling even byte flushed one cycle after the fall event
    start_dl(1, 8'd0);
    wr_byte(1, 0, 8'h11);
    wr_byte(1, 1, 8'h22);
    wr_byte(1, 2, 8'h33);
    end_dl(1, c0);
    rom_end_checks(1, "pack_flush");
    check("pack_flush_cycle", 64'(last_cyc[1]), 64'(c0 + 2));
    check("pack_flush_data", 64'(data_b), 64'h0033);
    check("pack_flush_addr", 64'(addr_b), 64'h1);

    // Word packing: random addresses including out-of-map bytes
    start_dl(1, 8'd0);
    for (int n = 0; n < 40; n++) wr_byte(1, $urandom_range(0, 'h19), 8'($urandom));
    end_dl(1, c0);
    rom_end_checks(1, "pack_rand");

    // Reset in the middle of a ROM stream
    start_dl(0, 8'd0);
    for (int a = 0; a < 'h100; a++) wr_byte(0, a, 8'($urandom));
    rst = 1'b1;
    #1;
    zero_checks("mid_reset");
    dl[0] = 1'b0;
    exp_q0.delete();
    for (int r = 0; r < 3; r++) strobe_cnt[0][r] = 0;
    idle(3);
    rst = 1'b0;
    idle(2);
    start_dl(0, 8'd0);
    for (int a = 0; a < 'h800; a++) wr_byte(0, a, 8'($urandom));
    end_dl(0, c0);
    rom_end_checks(0, "post_reset");
    check("post_reset_done", 64'(done_a), 64'b001);
    check("post_reset_cnt0", 64'(strobe_cnt[0][0]), 64'h800);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/rom_region_loader.md
Name: rom_region_loader

Overview:
- Parametrised replacement for the hand-written ioctl decoding in the arcade top level (fixed ROM address windows, mod latch, DIP capture).
- Routes ROM download bytes from hps_io to NREG ROM regions. Each region has a base and a size.
- Optionally packs bytes into 16-bit words, captures core-mod and DIP bytes, and reports per-region completion and out-of-map errors.
- Sits between hps_io and the dpram instances in every arcade core.

Parameters:
- NREG, 4: number of ROM regions (1..8).
- RAW, 16: region-local address width of rom_addr, in words.
- DWB, 1: bytes per output word, 1 or 2.
- REG_BASE, {NREG x 25'h0}: packed byte base address per region; region i at bits [25*i +: 25].
- REG_SIZE, {NREG x 25'h0}: packed byte size per region; even when DWB=2.
- ROM_IDX, 8'd0: ioctl_index for ROM data.
- MOD_IDX, 8'd1: ioctl_index for the core-mod byte.
- DIP_IDX, 8'd254: ioctl_index for DIP bytes.
- NDIP, 8: number of DIP bytes captured.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ioctl_download  in  1  download active
- ioctl_wr  in  1  byte strobe, one clk_sys cycle
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- ioctl_index  in  8  download index
- rom_we  out  NREG  one-hot word write strobe
- rom_addr  out  RAW  region-local word address
- rom_data  out  8*DWB  word data; low byte = even address
- region_done  out  NREG  region fully written during last ROM download
- dl_busy  out  1  ROM download in progress
- dl_done  out  1  last ROM download finished without error
- map_err  out  1  sticky: ROM byte outside every region
- core_mod  out  8  mod byte, applied at download end
- dip_sw  out  8*NDIP  DIP bytes; byte k at [8k +: 8]

Behaviour:
- Reset (async, clears all registers): rom_we=0, rom_addr=0, rom_data=0, region_done=0, dl_busy=0, dl_done=0, map_err=0, core_mod=0, dip_sw=0.
- Edge detection: ioctl_download is registered once. Rise/fall events are taken from this registered copy.
- Stage 1, decode (cycle after ioctl_wr with index ROM_IDX and download high):
  - Compute match[i] = addr>=base_i && addr<base_i+size_i.
  - Region select is the lowest matching index.
  - Register select, offset = addr-base, and the data byte.
  - No match: set map_err, emit no write.
- Stage 2, emit, DWB=1:
  - rom_we[sel] pulses for exactly 1 cycle, 2 cycles after ioctl_wr.
  - rom_addr = offset[RAW-1:0]; rom_data = byte.
- Stage 2, emit, DWB=2:
  - Even offset: hold byte in low-byte latch, no strobe.
  - Odd offset: pulse rom_we with {byte, latch}, rom_addr = offset>>1.
  - An odd byte with no preceding even byte in the same region writes with low byte 0.
  - A dangling even byte at download end is flushed with high byte 0 on the cycle after the fall event.
- Per-region byte counters reset on the ROM download rise event. region_done[i] = (count_i == size_i) at the fall event; cleared at the rise event.
- dl_busy: set on rise with index ROM_IDX, cleared on fall.
- dl_done: cleared on rise; set on fall when map_err==0.
- map_err: cleared on the next ROM download rise event.
- Mod index:
  - Each write stores the byte into a shadow register.
  - core_mod loads the shadow on the fall event only, so core select never glitches mid-download.
- DIP index: write with addr < NDIP stores dip_sw[addr]; higher addresses are ignored. No settle delay.
- Writes with any other index are ignored.
- Back-to-back ioctl_wr on consecutive cycles must be sustained. The pipeline accepts one byte per cycle.
- Reset mid-download: all state cleared. The next ROM download restarts counters; nothing partial is flushed.

Decomposition:
- Package loader_pkg:
  - Function region_base(i) and region_size(i), slicing the packed parameters.
  - Localparams for default indices 0, 1 and 254.
  - Typedef for the per-region 25-bit counter.
- Sub-module loader_pack: byte-to-word packer with flush input, instantiated once. For DWB=1 it is a pass-through register.

Test Plan:
- Regions {0x0000/0x8000, 0xE000/0x1000, 0xFF00/0x10000}, DWB=1; stream 0x0000..0x1FEFF -> rom_we[0] 32768 times, [1] 4096 times, [2] 65536 times. Bytes 0x8000..0xDFFF and 0xF000..0xFEFF set map_err=1, so dl_done=0. region_done=3'b111.
- DWB=2, region 0 size 4; bytes AA BB CC DD at 0..3 -> two strobes: addr 0 data 0xBBAA, addr 1 data 0xDDCC; region_done[0]=1.
- DWB=2, region 0 size 4; download ends after 3 bytes -> flush strobe addr 1 data 0x00CC one cycle after fall; region_done[0]=0.
- Mod byte 0x03 written mid-download -> core_mod stays 0x00 until fall, then 0x03.
- DIP writes addr 0=0x5A, addr 9=0xFF -> dip_sw[7:0]=0x5A; no other byte changes.
- Reset asserted mid-ROM stream -> all outputs 0 the same cycle. A new download writes region 0 from offset 0 with correct counters.
